assoc_sim_argmax: RTL

Sequential similarity accumulator and arg-max stage in the associative module. It sits directly downstream of the 128-bit popcount adder tree. Each cycle it consumes one 8-bit chunk popcount of (query AND class hypervector). It sums the chunk counts per class over a full hypervector and reports the class with the highest overlap score once all classes are scanned.

---
 rtl/assoc_sim_argmax.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/assoc_sim_argmax.sv
// Sequential per-class similarity accumulator with arg-max over a full query scan.
// Consumes one chunk popcount per valid cycle, in class-major order.
module assoc_sim_argmax #(
  parameter int NUM_CLASSES = 8,
  parameter int CHUNKS      = 16,
  parameter int CLASS_W     = $clog2(NUM_CLASSES),
  parameter int ACC_W       = 8 + $clog2(CHUNKS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_in_valid,
  input  logic [7:0]         i_pop_in,
  output logic               o_busy,
  output logic               o_done,
  output logic [CLASS_W-1:0] o_best_class,
  output logic [ACC_W-1:0]   o_best_score
);

  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [CHUNK_W-1:0] CHUNK_ONE  = CHUNK_W'(1);
  localparam logic [CLASS_W-1:0] CLASS_ONE  = CLASS_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [CHUNK_W-1:0]   r_chunk_cnt;
  logic [CLASS_W-1:0]   r_class_cnt;
  logic [ACC_W-1:0]     r_acc;
  logic [ACC_W-1:0]     r_run_best_score;
  logic [CLASS_W-1:0]   r_run_best_class;
  logic                 r_busy;
  logic                 r_done;
  logic [CLASS_W-1:0]   r_best_class;
  logic [ACC_W-1:0]     r_best_score;

  logic [ACC_W-1:0]     w_final;
  logic                 w_last_chunk;
  logic                 w_last_class;
  logic                 w_take_new;
  logic [ACC_W-1:0]     w_new_score;
  logic [CLASS_W-1:0]   w_new_class;

  assign w_final      = r_acc + ACC_W'(i_pop_in);
  assign w_last_chunk = (r_chunk_cnt == LAST_CHUNK);
  assign w_last_class = (r_class_cnt == LAST_CLASS);

  // Running-best candidate for the class that completes this cycle; class 0 always seeds it.
  always_comb begin
    w_take_new  = 1'b0;
    w_new_score = r_run_best_score;
    w_new_class = r_run_best_class;
    if ((w_final > r_run_best_score) || (r_class_cnt == {CLASS_W{1'b0}})) begin
      w_take_new  = 1'b1;
      w_new_score = w_final;
      w_new_class = r_class_cnt;
    end else begin
      w_take_new  = 1'b0;
    end
  end

  // Scan FSM: counters, accumulator, running best and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_chunk_cnt      <= {CHUNK_W{1'b0}};
      r_class_cnt      <= {CLASS_W{1'b0}};
      r_acc            <= {ACC_W{1'b0}};
      r_run_best_score <= {ACC_W{1'b0}};
      r_run_best_class <= {CLASS_W{1'b0}};
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_best_class     <= {CLASS_W{1'b0}};
      r_best_score     <= {ACC_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state          <= S_RUN;
            r_busy           <= 1'b1;
            r_chunk_cnt      <= {CHUNK_W{1'b0}};
            r_class_cnt      <= {CLASS_W{1'b0}};
            r_acc            <= {ACC_W{1'b0}};
            r_run_best_score <= {ACC_W{1'b0}};
            r_run_best_class <= {CLASS_W{1'b0}};
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_RUN: begin
          r_busy <= 1'b1;
          r_done <= 1'b0;
          if (i_in_valid) begin
            if (w_last_chunk) begin
              r_run_best_score <= w_new_score;
              r_run_best_class <= w_new_class;
              r_acc            <= {ACC_W{1'b0}};
              r_chunk_cnt      <= {CHUNK_W{1'b0}};
              // Publishing here makes the results visible in the single DONE cycle.
              if (w_last_class) begin
                r_state      <= S_DONE;
                r_class_cnt  <= {CLASS_W{1'b0}};
                r_best_score <= w_new_score;
                r_best_class <= w_new_class;
                r_done       <= 1'b1;
              end else begin
                r_class_cnt  <= r_class_cnt + CLASS_ONE;
              end
            end else begin
              r_acc       <= w_final;
              r_chunk_cnt <= r_chunk_cnt + CHUNK_ONE;
            end
          end else begin
            r_acc <= r_acc;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_best_class = r_best_class;
  assign o_best_score = r_best_score;

endmodule
